// File: rtl/seq_pattern_gen_if.sv
// rtl/seq_pattern_gen_if.sv - beat stream from the sequence generator towards the sink
interface seq_pattern_gen_if #(
    parameter int OUT_W = 1
);
    logic [OUT_W-1:0] data_out;
    logic             data_out_valid;
    logic             data_out_ready;

    modport master (output data_out, output data_out_valid, input data_out_ready);
    modport slave  (input data_out, input data_out_valid, output data_out_ready);
endinterface

// File: rtl/seq_pattern_gen.sv
// rtl/seq_pattern_gen.sv - burst/continuous test-sequence source: pattern, PRBS7, PRBS15 or counter
module seq_pattern_gen #(
    parameter  int OUT_W = 1,
    parameter  int PAT_W = 32,
    parameter  int CNT_W = 16,
    localparam int LEN_W = $clog2(PAT_W) + 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               i_ena,
    input  logic [1:0]         i_mode,
    input  logic [PAT_W-1:0]   i_pattern,
    input  logic [LEN_W-1:0]   i_pat_len,
    input  logic [CNT_W-1:0]   i_burst_len,
    output logic               o_busy,
    output logic               o_done,
    seq_pattern_gen_if.master  m_if
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [1:0]         r_mode;
    logic [PAT_W-1:0]   r_pattern;
    logic [LEN_W-1:0]   r_len, r_idx;
    logic [CNT_W-1:0]   r_burst, r_cnt;
    logic [6:0]         r_prbs7;
    logic [14:0]        r_prbs15;
    logic [OUT_W-1:0]   r_ctr, r_data;

    logic               w_start, w_accept, w_last, w_idle;
    logic [LEN_W-1:0]   w_len_eff, w_src_len, w_src_idx, w_nxt_idx;
    logic [1:0]         w_src_mode;
    logic [PAT_W-1:0]   w_src_pat, w_pat_sh;
    logic [6:0]         w_src_p7, w_nxt_p7;
    logic [14:0]        w_src_p15, w_nxt_p15;
    logic [OUT_W-1:0]   w_src_ctr, w_beat, w_b_pat, w_b_p7, w_b_p15;

    assign w_idle    = (r_state == S_IDLE);
    assign w_start   = w_idle && i_ena;
    assign w_accept  = (r_state == S_RUN) && i_ena && m_if.data_out_ready;
    assign w_last    = w_accept && (r_burst != '0) && ((r_cnt + CNT_W'(1)) == r_burst);
    assign w_len_eff = ((i_pat_len == '0) || (i_pat_len > LEN_W'(PAT_W))) ? LEN_W'(PAT_W) : i_pat_len;

    // In IDLE the generator is fed from the inputs and fresh seeds so the first beat is ready at start.
    assign w_src_mode = w_idle ? i_mode    : r_mode;
    assign w_src_pat  = w_idle ? i_pattern : r_pattern;
    assign w_src_len  = w_idle ? w_len_eff : r_len;
    assign w_src_idx  = w_idle ? w_len_eff - LEN_W'(1) : r_idx;
    assign w_src_p7   = w_idle ? '1 : r_prbs7;
    assign w_src_p15  = w_idle ? '1 : r_prbs15;
    assign w_src_ctr  = w_idle ? '0 : r_ctr;

    always_comb begin
        w_b_pat   = '0;
        w_b_p7    = '0;
        w_b_p15   = '0;
        w_pat_sh  = '0;
        w_nxt_idx = w_src_idx;
        w_nxt_p7  = w_src_p7;
        w_nxt_p15 = w_src_p15;
        for (int k = OUT_W - 1; k >= 0; k--) begin
            w_pat_sh   = w_src_pat >> w_nxt_idx;
            w_b_pat[k] = w_pat_sh[0];
            w_nxt_idx  = (w_nxt_idx == '0) ? w_src_len - LEN_W'(1) : w_nxt_idx - LEN_W'(1);
            w_b_p7[k]  = w_nxt_p7[6];
            w_nxt_p7   = {w_nxt_p7[5:0], w_nxt_p7[6] ^ w_nxt_p7[5]};
            w_b_p15[k] = w_nxt_p15[14];
            w_nxt_p15  = {w_nxt_p15[13:0], w_nxt_p15[14] ^ w_nxt_p15[13]};
        end
        case (w_src_mode)
            2'd0:    w_beat = w_b_pat;
            2'd1:    w_beat = w_b_p7;
            2'd2:    w_beat = w_b_p15;
            default: w_beat = w_src_ctr;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next              = r_state;
        o_busy              = 1'b0;
        o_done              = 1'b0;
        m_if.data_out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_ena) w_next = S_RUN;
            end
            S_RUN: begin
                o_busy              = 1'b1;
                m_if.data_out_valid = 1'b1;
                if (!i_ena)      w_next = S_IDLE;
                else if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign m_if.data_out = r_data;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mode    <= '0;
            r_pattern <= '0;
            r_len     <= '0;
            r_idx     <= '0;
            r_burst   <= '0;
            r_cnt     <= '0;
            r_prbs7   <= '1;
            r_prbs15  <= '1;
            r_ctr     <= '0;
            r_data    <= '0;
        end else if (w_start) begin
            r_mode    <= i_mode;
            r_pattern <= i_pattern;
            r_len     <= w_len_eff;
            r_burst   <= i_burst_len;
            r_cnt     <= '0;
            r_data    <= w_beat;
            r_idx     <= w_nxt_idx;
            r_prbs7   <= w_nxt_p7;
            r_prbs15  <= w_nxt_p15;
            r_ctr     <= w_src_ctr + OUT_W'(1);
        end else if (w_accept) begin
            r_cnt     <= r_cnt + CNT_W'(1);
            r_data    <= w_beat;
            r_idx     <= w_nxt_idx;
            r_prbs7   <= w_nxt_p7;
            r_prbs15  <= w_nxt_p15;
            r_ctr     <= w_src_ctr + OUT_W'(1);
        end
    end
endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb/tb_seq_pattern_gen.sv - three widths of seq_pattern_gen in lockstep against a bit-stream model
module tb_seq_pattern_gen;
    logic        clk = 1'b0, rstn = 1'b0, ena = 1'b0, ready = 1'b0;
    logic [1:0]  mode = '0;
    logic [31:0] pattern = '0;
    logic [5:0]  pat_len = '0;
    logic [15:0] burst_len = '0;
    logic        busy1, done1, busy4, done4, busy8, done8;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    seq_pattern_gen_if #(.OUT_W(1)) if1 ();
    seq_pattern_gen_if #(.OUT_W(4)) if4 ();
    seq_pattern_gen_if #(.OUT_W(8)) if8 ();
    assign if1.data_out_ready = ready;
    assign if4.data_out_ready = ready;
    assign if8.data_out_ready = ready;

    seq_pattern_gen #(.OUT_W(1)) u1 (.clk(clk), .rstn(rstn), .i_ena(ena), .i_mode(mode), .i_pattern(pattern),
        .i_pat_len(pat_len), .i_burst_len(burst_len), .o_busy(busy1), .o_done(done1), .m_if(if1.master));
    seq_pattern_gen #(.OUT_W(4)) u4 (.clk(clk), .rstn(rstn), .i_ena(ena), .i_mode(mode), .i_pattern(pattern),
        .i_pat_len(pat_len), .i_burst_len(burst_len), .o_busy(busy4), .o_done(done4), .m_if(if4.master));
    seq_pattern_gen #(.OUT_W(8)) u8 (.clk(clk), .rstn(rstn), .i_ena(ena), .i_mode(mode), .i_pattern(pattern),
        .i_pat_len(pat_len), .i_burst_len(burst_len), .o_busy(busy8), .o_done(done8), .m_if(if8.master));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sources as infinite bit streams; a beat of width w is bits n*w .. n*w+w-1, earliest in the MSB.
    bit p7[127];
    bit p15[32767];

    function automatic int eff_len(input int l);
        return (l == 0 || l > 32) ? 32 : l;
    endfunction

    function automatic bit stream_bit(input logic [1:0] md, input logic [31:0] pat, input int len, input int j);
        if (md == 2'd0) return pat[len - 1 - (j % len)];
        if (md == 2'd1) return p7[j % 127];
        return p15[j % 32767];
    endfunction

    function automatic logic [7:0] beat_val(input int w, input logic [1:0] md, input logic [31:0] pat,
                                            input int len, input int n);
        logic [7:0] v = '0;
        if (md == 2'd3) return 8'(n % (1 << w));
        for (int k = 0; k < w; k++) v[w - 1 - k] = stream_bit(md, pat, len, n * w + k);
        return v;
    endfunction

    // Run-level model: phase 0 idle, 1 streaming, 2 done pulse; m_beat = beats accepted since start.
    int          m_phase = 0, m_beat = 0, m_len = 32, m_burst = 0;
    logic [1:0]  m_mode = '0;
    logic [31:0] m_pat = '0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_phase <= 0;
            m_beat  <= 0;
        end else if (m_phase == 0) begin
            if (ena) begin
                m_phase <= 1; m_beat <= 0; m_mode <= mode; m_pat <= pattern;
                m_len <= eff_len(int'(pat_len)); m_burst <= int'(burst_len);
            end
        end else if (m_phase == 1) begin
            if (!ena) m_phase <= 0;
            else if (ready) begin
                m_beat <= m_beat + 1;
                if (m_burst != 0 && m_beat + 1 == m_burst) m_phase <= 2;
            end
        end else begin
            m_phase <= 0;
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            chk("valid1", if1.data_out_valid, m_phase == 1);
            chk("valid4", if4.data_out_valid, m_phase == 1);
            chk("valid8", if8.data_out_valid, m_phase == 1);
            chk("busy1", busy1, m_phase == 1);
            chk("busy8", busy8, m_phase == 1);
            chk("done1", done1, m_phase == 2);
            chk("done4", done4, m_phase == 2);
            chk("done8", done8, m_phase == 2);
            if (m_phase == 1) begin
                chk("data1", if1.data_out, beat_val(1, m_mode, m_pat, m_len, m_beat));
                chk("data4", if4.data_out, beat_val(4, m_mode, m_pat, m_len, m_beat));
                chk("data8", if8.data_out, beat_val(8, m_mode, m_pat, m_len, m_beat));
            end
        end
    end

    logic [7:0] q1[$], q4[$], q8[$];
    always @(negedge clk) begin
        if (rstn && if1.data_out_valid && ready) begin
            q1.push_back(8'(if1.data_out));
            q4.push_back(8'(if4.data_out));
            q8.push_back(if8.data_out);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [1:0] md, input logic [31:0] pat, input logic [5:0] len, input logic [15:0] bl);
        step();
        q1.delete(); q4.delete(); q8.delete();
        mode = md; pattern = pat; pat_len = len; burst_len = bl; ready = 1'b1; ena = 1'b1;
    endtask

    task automatic wait_done(input string name, input int maxcyc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done1 && n < maxcyc);
        chk(name, done1, 1'b1);
        step();
        ena = 1'b0;
        step();
        step();
    endtask

    task automatic chk_q(input string name, input logic [7:0] q[$], input int idx, input logic [7:0] exp);
        chk(name, (idx < q.size()) ? q[idx] : 8'hxx, exp);
    endtask

    initial begin
        logic [7:0] e1[6] = '{1, 0, 1, 1, 0, 1};
        logic       rp[5] = '{1, 0, 0, 1, 1};
        logic [7:0] e5[5] = '{1, 1, 0, 1, 0};
        int ones, n;

        for (int i = 0; i < 7; i++) p7[i] = 1'b1;
        for (int i = 0; i < 120; i++) p7[i + 7] = p7[i] ^ p7[i + 1];
        for (int i = 0; i < 15; i++) p15[i] = 1'b1;
        for (int i = 0; i < 32752; i++) p15[i + 15] = p15[i] ^ p15[i + 1];

        // Model pins from hand-derived values.
        chk("pin_pat4_b0", beat_val(4, 0, 32'b1010, 4, 0), 8'hA);
        chk("pin_pat4_b1", beat_val(4, 0, 32'b1010, 4, 1), 8'hA);
        chk("pin_pat3_b0", beat_val(4, 0, 32'b101, 3, 0), 8'hB);
        chk("pin_pat3_b1", beat_val(4, 0, 32'b101, 3, 1), 8'h6);
        chk("pin_prbs7_b7", beat_val(1, 1, 0, 32, 7), 8'h0);
        chk("pin_prbs7_b0", beat_val(8, 1, 0, 32, 0), 8'hFE);
        chk("pin_cnt_300", beat_val(8, 3, 0, 32, 300), 8'd44);
        ones = 0;
        for (int i = 0; i < 127; i++) ones += int'(p7[i]);
        chk("pin_prbs7_ones", ones, 64);

        repeat (3) @(negedge clk);
        chk("rst_valid", if1.data_out_valid, 0);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done4, 0);
        chk("rst_data8", if8.data_out, 0);
        chk("rst_data4", if4.data_out, 0);
        step();
        rstn = 1'b1;

        start(2'd0, 32'b101, 6'd3, 16'd6);
        wait_done("t1_done", 40);
        chk("t1_count", q1.size(), 6);
        for (int i = 0; i < 6; i++) chk_q("t1_beat", q1, i, e1[i]);
        chk_q("t1_w4_b0", q4, 0, 8'hB);
        chk_q("t1_w4_b1", q4, 1, 8'h6);
        chk_q("t1_w8_b0", q8, 0, 8'hB6);
        chk_q("t1_w8_b1", q8, 1, 8'hDB);

        start(2'd0, 32'b1010, 6'd4, 16'd2);
        wait_done("t2_done", 20);
        chk("t2_count", q4.size(), 2);
        chk_q("t2_b0", q4, 0, 8'hA);
        chk_q("t2_b1", q4, 1, 8'hA);

        start(2'd3, 32'h0, 6'd0, 16'd3);
        for (int i = 0; i < 5; i++) begin
            step();
            ready = rp[i];
        end
        wait_done("t3_done", 10);
        ready = 1'b1;
        chk("t3_count", q8.size(), 3);
        for (int i = 0; i < 3; i++) chk_q("t3_beat", q8, i, 8'(i));

        start(2'd1, 32'h0, 6'd0, 16'd254);
        wait_done("t4_done", 300);
        chk("t4_count", q1.size(), 254);
        for (int i = 0; i < 7; i++) chk_q("t4_ones", q1, i, 8'h1);
        chk_q("t4_b8", q1, 7, 8'h0);
        chk_q("t4_b128", q1, 127, 8'h1);
        ones = 0;
        for (int i = 0; i < 127 && i < q1.size(); i++) ones += int'(q1[i]);
        chk("t4_period_ones", ones, 64);

        start(2'd0, 32'b11010, 6'd5, 16'd0);
        n = 0;
        while (q1.size() < 10 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("t5_ten_beats", q1.size() >= 10, 1);
        step();
        ena = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t5_abort_valid", if1.data_out_valid, 0);
        chk("t5_abort_busy", busy1, 0);
        chk("t5_abort_done", done1, 0);
        start(2'd0, 32'b11010, 6'd5, 16'd0);
        n = 0;
        while (q1.size() < 5 && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) chk_q("t5_restart", q1, i, e5[i]);
        chk_q("t5_restart_w4", q4, 0, 8'hD);
        step();
        ena = 1'b0;
        step();

        start(2'd2, 32'h0, 6'd0, 16'd20);
        repeat (5) @(negedge clk);
        step();
        rstn = 1'b0;
        ena = 1'b0;
        #1;
        chk("t6_valid", if8.data_out_valid, 0);
        chk("t6_busy", busy1, 0);
        chk("t6_done", done1, 0);
        chk("t6_data8", if8.data_out, 0);
        chk("t6_data1", if1.data_out, 0);
        step();
        rstn = 1'b1;
        start(2'd3, 32'h0, 6'd0, 16'd4);
        wait_done("t6_done_after", 20);
        chk("t6_count", q8.size(), 4);
        for (int i = 0; i < 4; i++) chk_q("t6_beat", q8, i, 8'(i));

        for (int c = 0; c < 2500; c++) begin
            step();
            ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) begin
                mode      = 2'($urandom_range(0, 3));
                pattern   = $urandom;
                pat_len   = 6'($urandom_range(0, 63));
                burst_len = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 20));
            end
            if (!ena) ena = ($urandom_range(0, 9) < 3);
            else if ($urandom_range(0, 99) < 3 || m_beat > 800) ena = 1'b0;
        end
        step();
        ena = 1'b0;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1);
    end
endmodule
